vga_sync_gen: RTL and testbench

- Generates horizontal/vertical VGA sync timing and the pixel-rate enable for the display path.
- Its H/V time outputs and enables drive the per-axis pixel address counters and the frame-buffer read side.
- It is the timing source those counters consume; it never touches pixel data.
- Defaults: 640x480@60 from a 50 MHz CLK with a /2 pixel enable.

---
 rtl/vga_sync_gen_if.sv | 26 ++
 rtl/vga_sync_gen.sv | 117 +++++++++++
 tb/tb_vga_sync_gen.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/vga_sync_gen_if.sv
`default_nettype none
// -----------------------------------------------------------------------------
// vga_sync_gen_if : timing bundle from the sync generator to its consumers
// Revision 1.0
// -----------------------------------------------------------------------------
interface vga_sync_gen_if;
  logic       PIX_ENABLE;
  logic       LINE_ENABLE;
  logic [9:0] H_SYNCH_TIME;
  logic [9:0] V_SYNCH_TIME;
  logic       HS;
  logic       VS;
  logic       DISPLAY_ON;
  logic       FRAME_START;

  modport master (
    output PIX_ENABLE, LINE_ENABLE, H_SYNCH_TIME, V_SYNCH_TIME,
           HS, VS, DISPLAY_ON, FRAME_START
  );

  modport slave (
    input  PIX_ENABLE, LINE_ENABLE, H_SYNCH_TIME, V_SYNCH_TIME,
           HS, VS, DISPLAY_ON, FRAME_START
  );
endinterface
`default_nettype wire

// File: rtl/vga_sync_gen.sv
`default_nettype none
// -----------------------------------------------------------------------------
// vga_sync_gen : VGA H/V sync timing and pixel-rate enable generator
// Revision 1.0
// -----------------------------------------------------------------------------
module vga_sync_gen #(
  parameter int CLK_DIV            = 2,
  parameter int HOR_TOTAL          = 800,
  parameter int HOR_PULSE          = 96,
  parameter int HOR_BACK_PORCH_END = 144,
  parameter int HOR_DISPLAY_END    = 784,
  parameter int VER_TOTAL          = 521,
  parameter int VER_PULSE          = 2,
  parameter int VER_BACK_PORCH_END = 31,
  parameter int VER_DISPLAY_END    = 511
) (
  input  wire logic      CLK,
  input  wire logic      RESET_N,
  vga_sync_gen_if.master sync
);

  localparam int         c_div_w = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [9:0] c_h_max = 10'(HOR_TOTAL - 1);
  localparam logic [9:0] c_v_max = 10'(VER_TOTAL - 1);
  localparam logic [9:0] c_h_pls = 10'(HOR_PULSE);
  localparam logic [9:0] c_v_pls = 10'(VER_PULSE);
  localparam logic [9:0] c_h_bpe = 10'(HOR_BACK_PORCH_END);
  localparam logic [9:0] c_h_dpe = 10'(HOR_DISPLAY_END);
  localparam logic [9:0] c_v_bpe = 10'(VER_BACK_PORCH_END);
  localparam logic [9:0] c_v_dpe = 10'(VER_DISPLAY_END);

  logic       div_tick;
  logic       pix_enable;
  logic       h_last;
  logic       v_last;
  logic [9:0] h_q, h_d;
  logic [9:0] v_q, v_d;
  logic       hs_q, hs_d;
  logic       vs_q, vs_d;
  logic       display_on_q, display_on_d;
  logic       frame_start_q, frame_start_d;

  generate
    if (CLK_DIV > 1) begin : g_div
      localparam logic [c_div_w-1:0] c_div_max = c_div_w'(CLK_DIV - 1);
      logic [c_div_w-1:0] div_q, div_d;

      always_comb begin
        div_d = (div_q == c_div_max) ? '0 : div_q + c_div_w'(1);
      end

      always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
          div_q <= '0;
        end else begin
          div_q <= div_d;
        end
      end

      assign div_tick = (div_q == c_div_max);
    end else begin : g_no_div
      // Undivided: every clock is a pixel tick.
      assign div_tick = 1'b1;
    end
  endgenerate

  // Enables are forced low combinationally while reset is held.
  assign pix_enable = div_tick & RESET_N;
  assign h_last     = (h_q == c_h_max);
  assign v_last     = (v_q == c_v_max);

  always_comb begin
    h_d = h_q;
    v_d = v_q;
    if (pix_enable) begin
      h_d = h_last ? '0 : h_q + 10'd1;
      if (h_last) begin
        v_d = v_last ? '0 : v_q + 10'd1;
      end
    end
    // Decode from next-state counters so the flops line up with H/V.
    hs_d          = (h_d >= c_h_pls);
    vs_d          = (v_d >= c_v_pls);
    display_on_d  = (h_d > c_h_bpe) && (h_d <= c_h_dpe) &&
                    (v_d > c_v_bpe) && (v_d <= c_v_dpe);
    frame_start_d = pix_enable && h_last && v_last;
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      h_q           <= '0;
      v_q           <= '0;
      hs_q          <= 1'b0;
      vs_q          <= 1'b0;
      display_on_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      h_q           <= h_d;
      v_q           <= v_d;
      hs_q          <= hs_d;
      vs_q          <= vs_d;
      display_on_q  <= display_on_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign sync.PIX_ENABLE   = pix_enable;
  assign sync.LINE_ENABLE  = pix_enable & h_last;
  assign sync.H_SYNCH_TIME = h_q;
  assign sync.V_SYNCH_TIME = v_q;
  assign sync.HS           = hs_q;
  assign sync.VS           = vs_q;
  assign sync.DISPLAY_ON   = display_on_q;
  assign sync.FRAME_START  = frame_start_q;

endmodule
`default_nettype wire

// File: tb/tb_vga_sync_gen.sv
`default_nettype none
// -----------------------------------------------------------------------------
// tb_vga_sync_gen : scoreboard bench for three vga_sync_gen configurations
// Revision 1.0
// -----------------------------------------------------------------------------
module tb_vga_sync_gen;

  // Expected record: DUT index, cycle key since reset release, packed outputs
  // {pe, le, hs, vs, de, fs, h[9:0], v[9:0]}.
  typedef struct {
    int          dut;
    int          key;
    logic [25:0] val;
  } exp_t;

  logic        clk   = 1'b0;
  logic [2:0]  rst_n = 3'b111;
  int          cyc [3];
  int          vectors = 0;
  int          fails   = 0;
  int          de_cnt  = 0;
  exp_t        sb [$];
  logic [25:0] act [3];

  // DUT 0: defaults, DUT 1: small timing, DUT 2: defaults with /3 divider.
  int p_div [3] = '{2, 1, 3};
  int p_ht  [3] = '{800, 16, 800};
  int p_hp  [3] = '{96, 2, 96};
  int p_hb  [3] = '{144, 4, 144};
  int p_he  [3] = '{784, 12, 784};
  int p_vt  [3] = '{521, 8, 521};
  int p_vp  [3] = '{2, 1, 2};
  int p_vb  [3] = '{31, 2, 31};
  int p_ve  [3] = '{511, 6, 511};

  vga_sync_gen_if ifa ();
  vga_sync_gen_if ifb ();
  vga_sync_gen_if ifc ();

  vga_sync_gen u_dut_a (
    .CLK     (clk),
    .RESET_N (rst_n[0]),
    .sync    (ifa)
  );

  vga_sync_gen #(
    .CLK_DIV            (1),
    .HOR_TOTAL          (16),
    .HOR_PULSE          (2),
    .HOR_BACK_PORCH_END (4),
    .HOR_DISPLAY_END    (12),
    .VER_TOTAL          (8),
    .VER_PULSE          (1),
    .VER_BACK_PORCH_END (2),
    .VER_DISPLAY_END    (6)
  ) u_dut_b (
    .CLK     (clk),
    .RESET_N (rst_n[1]),
    .sync    (ifb)
  );

  vga_sync_gen #(
    .CLK_DIV (3)
  ) u_dut_c (
    .CLK     (clk),
    .RESET_N (rst_n[2]),
    .sync    (ifc)
  );

  assign act[0] = {ifa.PIX_ENABLE, ifa.LINE_ENABLE, ifa.HS, ifa.VS, ifa.DISPLAY_ON,
                   ifa.FRAME_START, ifa.H_SYNCH_TIME, ifa.V_SYNCH_TIME};
  assign act[1] = {ifb.PIX_ENABLE, ifb.LINE_ENABLE, ifb.HS, ifb.VS, ifb.DISPLAY_ON,
                   ifb.FRAME_START, ifb.H_SYNCH_TIME, ifb.V_SYNCH_TIME};
  assign act[2] = {ifc.PIX_ENABLE, ifc.LINE_ENABLE, ifc.HS, ifc.VS, ifc.DISPLAY_ON,
                   ifc.FRAME_START, ifc.H_SYNCH_TIME, ifc.V_SYNCH_TIME};

  always #5 clk = ~clk;

  // Key = clock edges since reset release; 0 while reset is held.
  always @(posedge clk) begin
    for (int d = 0; d < 3; d++) begin
      cyc[d] <= rst_n[d] ? cyc[d] + 1 : 0;
    end
  end

  // Closed-form timing: k edges after release have consumed k/DIV pixel ticks.
  function automatic logic [25:0] expect_at(input int d, input int k);
    int   n, h, v;
    logic pe, le, hs, vs, de, fs;
    n  = k / p_div[d];
    h  = n % p_ht[d];
    v  = (n / p_ht[d]) % p_vt[d];
    pe = ((k % p_div[d]) == p_div[d] - 1);
    le = pe && (h == p_ht[d] - 1);
    hs = (h >= p_hp[d]);
    vs = (v >= p_vp[d]);
    de = (h > p_hb[d]) && (h <= p_he[d]) && (v > p_vb[d]) && (v <= p_ve[d]);
    fs = ((k % p_div[d]) == 0) && (n > 0) && ((n % (p_ht[d] * p_vt[d])) == 0);
    return {pe, le, hs, vs, de, fs, 10'(h), 10'(v)};
  endfunction

  function automatic string fmt(input logic [25:0] x);
    return $sformatf("pe=%b le=%b hs=%b vs=%b de=%b fs=%b h=%0d v=%0d",
                     x[25], x[24], x[23], x[22], x[21], x[20], x[19:10], x[9:0]);
  endfunction

  task automatic push(input int d, input int k, input logic [25:0] v);
    exp_t e;
    e.dut = d;
    e.key = k;
    e.val = v;
    sb.push_back(e);
  endtask

  // Monitor: pops every expectation whose key matches the DUT's current cycle.
  always @(negedge clk) begin
    int key;
    for (int d = 0; d < 3; d++) begin
      key = rst_n[d] ? cyc[d] : 0;
      for (int i = sb.size() - 1; i >= 0; i--) begin
        if (sb[i].dut == d && sb[i].key == key) begin
          vectors++;
          if (act[d] !== sb[i].val) begin
            fails++;
            $display("FAIL dut%0d@key%0d: got %s, want %s",
                     d, key, fmt(act[d]), fmt(sb[i].val));
          end
          sb.delete(i);
        end
      end
    end
    if (rst_n[1] && cyc[1] >= 1 && cyc[1] <= 128 && act[1][21]) de_cnt++;
    if (rst_n[1] && cyc[1] == 129) begin
      vectors++;
      if (de_cnt != 32) begin
        fails++;
        $display("FAIL visible_count: got %0d, want 32", de_cnt);
      end
    end
  end

  initial begin
    int ka [14] = '{1, 2, 3, 4, 5, 190, 191, 192, 193, 1598, 1599, 1600, 1601, 2200};
    int kc [15] = '{1, 2, 3, 4, 5, 6, 285, 287, 288, 290, 2397, 2398, 2399, 2400, 2401};
    int kr [5]  = '{1, 2, 3, 4, 601};

    #1 rst_n = 3'b000;
    for (int d = 0; d < 3; d++) push(d, 0, 26'd0);
    foreach (ka[i]) push(0, ka[i], expect_at(0, ka[i]));
    for (int k = 1; k <= 260; k++) push(1, k, expect_at(1, k));
    foreach (kc[i]) push(2, kc[i], expect_at(2, kc[i]));

    repeat (5) @(posedge clk);
    #1 rst_n = 3'b111;

    for (int i = 0; i < 5000 && cyc[0] != 2201; i++) begin
      @(posedge clk);
      #1;
    end
    vectors++;
    if (cyc[0] != 2201) begin
      fails++;
      $display("FAIL reach_mid_line: got key %0d, want 2201", cyc[0]);
    end

    // Between edges, with H=300 V=1: outputs must clear with no clock edge.
    #1;
    push(0, 0, 26'd0);
    rst_n[0] = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    foreach (kr[i]) push(0, kr[i], expect_at(0, kr[i]));
    rst_n[0] = 1'b1;

    for (int i = 0; i < 4000 && sb.size() != 0; i++) @(posedge clk);
    while (sb.size() != 0) begin
      vectors++;
      fails++;
      $display("FAIL never_observed dut%0d@key%0d: got nothing, want %s",
               sb[0].dut, sb[0].key, fmt(sb[0].val));
      void'(sb.pop_front());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
`default_nettype wire
